// File: rtl/vend_pkg.sv
// vend_pkg: shared types, push encodings and price lookup for the vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_REFUND   = 2'd3
  } state_t;

  localparam logic [3:0] PUSH_IDLE = 4'b1000;
  localparam logic [3:0] PUSH_SEL  = 4'b0100;
  localparam logic [3:0] PUSH_DISP = 4'b0010;
  localparam logic [3:0] PUSH_REF  = 4'b0001;

  // Widest flat price vector the lookup accepts; callers zero-extend into it.
  localparam int PT_MAX_W = 1024;

  // Pulls entry idx (vw bits wide) out of a flat price vector.
  function automatic logic [31:0] price_of(input logic [PT_MAX_W-1:0] pt,
                                           input int idx, input int vw);
    logic [31:0] mask;
    mask = (vw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << vw) - 32'd1);
    return 32'(pt >> (idx * vw)) & mask;
  endfunction

  function automatic logic [3:0] push_of(input state_t s);
    case (s)
      ST_IDLE:     return PUSH_IDLE;
      ST_CREDIT:   return PUSH_SEL;
      ST_DISPENSE: return PUSH_DISP;
      default:     return PUSH_REF;
    endcase
  endfunction

endpackage

// File: rtl/vend_if.sv
// vend_if: coin/selection strobes plus the dispense and change handshakes.
// master = customer/mechanism side, slave = controller side.
interface vend_if #(
  parameter int NUM_ITEMS = 4,
  parameter int VW        = 8
);
  localparam int IW = $clog2(NUM_ITEMS);

  logic          coin_valid;
  logic [VW-1:0] coin_value;
  logic          sel_valid;
  logic [IW-1:0] sel_item;
  logic          cancel;
  logic          dispense_ack;
  logic          change_ack;
  logic          dispense_valid;
  logic [IW-1:0] dispense_item;
  logic          change_valid;
  logic [VW-1:0] change_value;
  logic          coin_reject;
  logic          sel_reject;

  modport master (
    output coin_valid, coin_value, sel_valid, sel_item, cancel,
           dispense_ack, change_ack,
    input  dispense_valid, dispense_item, change_valid, change_value,
           coin_reject, sel_reject
  );

  modport slave (
    input  coin_valid, coin_value, sel_valid, sel_item, cancel,
           dispense_ack, change_ack,
    output dispense_valid, dispense_item, change_valid, change_value,
           coin_reject, sel_reject
  );

endinterface

// File: rtl/vend_credit.sv
// vend_credit: credit accumulator with ceiling check and registered coin reject.
// The FSM decides whether a coin is taken (load/add); anything strobed but not
// taken is rejected one cycle later.
module vend_credit #(
  parameter int VW         = 8,
  parameter int MAX_CREDIT = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_valid,
  input  logic [VW-1:0] coin_value,
  input  logic          load,
  input  logic          add,
  input  logic          clear,
  output logic [VW-1:0] credit,
  output logic          coin_fits,
  output logic          coin_reject
);

  localparam logic [VW:0] MAX_C = (VW+1)'(MAX_CREDIT);

  logic [VW:0] sum;

  // Sum carried one bit wide so an overflowing coin is caught instead of wrapping.
  always_comb begin
    sum       = {1'b0, credit} + {1'b0, coin_value};
    coin_fits = (coin_value != '0) && (sum <= MAX_C);
  end

  // Credit register and reject pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit      <= '0;
      coin_reject <= 1'b0;
    end else begin
      if (clear)     credit <= '0;
      else if (load) credit <= coin_value;
      else if (add)  credit <= sum[VW-1:0];
      coin_reject <= coin_valid & ~(load | add);
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: multi-item vending sequencer with dispense and change handshakes.
// Optional build macro VEND_TIMEOUT_EN adds an inactivity auto-refund in CREDIT.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no credit held, waiting for first coin
// CREDIT   | accumulating coins, waiting for sel or cancel
// DISPENSE | dispense_valid high until dispense_ack
// REFUND   | change_valid high until change_ack
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int NUM_ITEMS   = 4,
  parameter int VW          = 8,
  parameter int MAX_CREDIT  = 200,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ITEMS*VW-1:0] price_table,
  output logic [3:0]             push,
  output logic [VW-1:0]          credit,
  vend_if.slave                  bus
);

  localparam int IW = $clog2(NUM_ITEMS);

  state_t        state, state_n;
  logic [IW-1:0] item_q, item_n;
  logic [VW-1:0] change_q, change_n;
  logic          sel_rej_q, sel_rej_n;
  logic [VW-1:0] price_sel;
  logic          sel_ok;
  logic          coin_fits;
  logic          load, add, clear;
  logic          timeout_hit;

  vend_credit #(
    .VW         (VW),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_credit (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (bus.coin_valid),
    .coin_value  (bus.coin_value),
    .load        (load),
    .add         (add),
    .clear       (clear),
    .credit      (credit),
    .coin_fits   (coin_fits),
    .coin_reject (bus.coin_reject)
  );

  // Selected item's price and whether the selection can be honoured now.
  always_comb begin
    price_sel = VW'(price_of(PT_MAX_W'(price_table), int'(bus.sel_item), VW));
    sel_ok    = (int'(bus.sel_item) < NUM_ITEMS) && (credit >= price_sel);
  end

`ifdef VEND_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] to_cnt;

  // Inactivity down-counter: reloaded outside CREDIT and on any activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= TO_LOAD;
    end else if ((state != ST_CREDIT) || bus.cancel || bus.sel_valid ||
                 (bus.coin_valid && coin_fits)) begin
      to_cnt <= TO_LOAD;
    end else if (to_cnt != '0) begin
      to_cnt <= to_cnt - TW'(1);
    end
  end

  assign timeout_hit = (state == ST_CREDIT) && (to_cnt == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state, datapath latches and accumulator controls.
  always_comb begin
    state_n   = state;
    item_n    = item_q;
    change_n  = change_q;
    sel_rej_n = 1'b0;
    load      = 1'b0;
    add       = 1'b0;
    clear     = 1'b0;
    case (state)
      ST_IDLE: begin
        sel_rej_n = bus.sel_valid;
        if (bus.coin_valid && coin_fits) begin
          load    = 1'b1;
          state_n = ST_CREDIT;
        end
      end
      ST_CREDIT: begin
        // cancel (or timeout) beats sel beats coin; a losing coin is rejected
        // simply by not asserting add.
        if (bus.cancel || timeout_hit) begin
          state_n   = ST_REFUND;
          change_n  = credit;
          sel_rej_n = bus.sel_valid;
        end else if (bus.sel_valid && sel_ok) begin
          state_n  = ST_DISPENSE;
          item_n   = bus.sel_item;
          change_n = credit - price_sel;
        end else begin
          sel_rej_n = bus.sel_valid;
          if (bus.coin_valid && coin_fits) add = 1'b1;
        end
      end
      ST_DISPENSE: begin
        sel_rej_n = bus.sel_valid;
        if (bus.dispense_ack) begin
          if (change_q != '0) begin
            state_n = ST_REFUND;
          end else begin
            state_n = ST_IDLE;
            clear   = 1'b1;
          end
        end
      end
      ST_REFUND: begin
        sel_rej_n = bus.sel_valid;
        if (bus.change_ack) begin
          state_n  = ST_IDLE;
          clear    = 1'b1;
          change_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State register; push is registered from the next state so it tracks state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      push      <= PUSH_IDLE;
      item_q    <= '0;
      change_q  <= '0;
      sel_rej_q <= 1'b0;
    end else begin
      state     <= state_n;
      push      <= push_of(state_n);
      item_q    <= item_n;
      change_q  <= change_n;
      sel_rej_q <= sel_rej_n;
    end
  end

  assign bus.dispense_valid = (state == ST_DISPENSE);
  assign bus.dispense_item  = item_q;
  assign bus.change_valid   = (state == ST_REFUND);
  assign bus.change_value   = change_q;
  assign bus.sel_reject     = sel_rej_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed vector table, random run against a transaction-level
// model, and (with VEND_TIMEOUT_EN) an inactivity refund sequence.
module tb_vend_ctrl;

  localparam int NI   = 4;
  localparam int VW   = 8;
  localparam int MAXC = 200;
  localparam int TO   = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NI*VW-1:0] price_table;
  logic [3:0]       push;
  logic [VW-1:0]    credit;

  vend_if #(.NUM_ITEMS(NI), .VW(VW)) bus ();

  vend_ctrl #(
    .NUM_ITEMS   (NI),
    .VW          (VW),
    .MAX_CREDIT  (MAXC),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .price_table (price_table),
    .push        (push),
    .credit      (credit),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] push;
    logic [7:0] credit;
    logic       dv;
    logic [1:0] di;
    logic       kv;
    logic [7:0] kval;
    logic       crej;
    logic       srej;
  } out_t;

  typedef struct {
    bit   r, cv;
    int   cval;
    bit   sv;
    int   si;
    bit   ca, da, ka;
    out_t exp;
  } vec_t;

  int prices [NI] = '{50, 75, 100, 120};
  int n_chk  = 0;
  int n_fail = 0;

  // reference model: phase 0 idle, 1 holding credit, 2 dispensing, 3 refunding
  int m_ph, m_credit, m_change, m_item, m_idle;
  bit m_crej, m_srej;

  function automatic vec_t mk(bit r, bit cv, int cval, bit sv, int si, bit ca, bit da, bit ka,
                              int p, int c, bit dv, int di, bit kv, int kval, bit crej, bit srej);
    vec_t v;
    v.r = r; v.cv = cv; v.cval = cval; v.sv = sv; v.si = si; v.ca = ca; v.da = da; v.ka = ka;
    v.exp.push = 4'(p);  v.exp.credit = 8'(c); v.exp.dv = dv; v.exp.di = 2'(di);
    v.exp.kv = kv;       v.exp.kval = 8'(kval); v.exp.crej = crej; v.exp.srej = srej;
    return v;
  endfunction

  function automatic out_t get_out();
    out_t o;
    o.push = push; o.credit = credit; o.dv = bus.dispense_valid; o.di = bus.dispense_item;
    o.kv = bus.change_valid; o.kval = bus.change_value; o.crej = bus.coin_reject;
    o.srej = bus.sel_reject;
    return o;
  endfunction

  function automatic out_t model_out();
    out_t o;
    o.push = 4'(8 >> m_ph); o.credit = 8'(m_credit); o.dv = (m_ph == 2); o.di = 2'(m_item);
    o.kv = (m_ph == 3); o.kval = 8'(m_change); o.crej = m_crej; o.srej = m_srej;
    return o;
  endfunction

  task automatic check(input string name, input out_t got, input out_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got push=%b credit=%0d dv=%b di=%0d kv=%b kval=%0d crej=%b srej=%b ; required push=%b credit=%0d dv=%b di=%0d kv=%b kval=%0d crej=%b srej=%b",
               name, got.push, got.credit, got.dv, got.di, got.kv, got.kval, got.crej, got.srej,
               exp.push, exp.credit, exp.dv, exp.di, exp.kv, exp.kval, exp.crej, exp.srej);
    end
  endtask

  task automatic drive(input bit r, input bit cv, input int cval, input bit sv, input int si,
                       input bit ca, input bit da, input bit ka);
    rst = r; bus.coin_valid = cv; bus.coin_value = 8'(cval); bus.sel_valid = sv;
    bus.sel_item = 2'(si); bus.cancel = ca; bus.dispense_ack = da; bus.change_ack = ka;
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit r, input bit cv, input int cval, input bit sv, input int si,
                            input bit ca, input bit da, input bit ka);
    bit hit, acc;
    hit = 1'b0; acc = 1'b0;
    m_crej = 1'b0; m_srej = 1'b0;
    if (r) begin
      m_ph = 0; m_credit = 0; m_change = 0; m_item = 0; m_idle = 0;
      return;
    end
    case (m_ph)
      0: begin
        m_srej = sv;
        if (cv) begin
          if (cval > 0 && cval <= MAXC) begin m_credit = cval; m_ph = 1; m_idle = 0; end
          else m_crej = 1'b1;
        end
      end
      1: begin
`ifdef VEND_TIMEOUT_EN
        hit = (m_idle == TO - 1);
`endif
        if (ca || hit) begin
          m_crej = cv; m_srej = sv; m_change = m_credit; m_ph = 3;
        end else if (sv && si < NI && prices[si] <= m_credit) begin
          m_crej = cv; m_item = si; m_change = m_credit - prices[si]; m_ph = 2;
        end else begin
          m_srej = sv;
          if (cv) begin
            if (cval > 0 && m_credit + cval <= MAXC) begin m_credit += cval; acc = 1'b1; end
            else m_crej = 1'b1;
          end
        end
        m_idle = (acc || sv || ca) ? 0 : m_idle + 1;
      end
      2: begin
        m_crej = cv; m_srej = sv;
        if (da) begin
          if (m_change > 0) m_ph = 3;
          else begin m_ph = 0; m_credit = 0; end
        end
      end
      default: begin
        m_crej = cv; m_srej = sv;
        if (ka) begin m_ph = 0; m_credit = 0; m_change = 0; end
      end
    endcase
  endtask

  vec_t tbl [$];

  initial begin
    price_table = {8'd120, 8'd100, 8'd75, 8'd50};
    rst = 1'b1;
    bus.coin_valid = 0; bus.coin_value = 0; bus.sel_valid = 0; bus.sel_item = 0;
    bus.cancel = 0; bus.dispense_ack = 0; bus.change_ack = 0;

    //             r cv cval sv si ca da ka   push cr dv di kv kval crej srej
    tbl.push_back(mk(1,0,  0,0,0,0,0,0,     8,  0,0,0,0,  0,0,0)); // reset
    tbl.push_back(mk(0,1, 25,0,0,0,0,0,     4, 25,0,0,0,  0,0,0));
    tbl.push_back(mk(0,1, 25,0,0,0,0,0,     4, 50,0,0,0,  0,0,0));
    tbl.push_back(mk(0,1, 25,0,0,0,0,0,     4, 75,0,0,0,  0,0,0));
    tbl.push_back(mk(0,0,  0,1,1,0,0,0,     2, 75,1,1,0,  0,0,0)); // exact price
    tbl.push_back(mk(0,1, 10,0,0,0,0,0,     2, 75,1,1,0,  0,1,0)); // coin in dispense
    tbl.push_back(mk(0,0,  0,0,0,0,1,0,     8,  0,0,1,0,  0,0,0));
    tbl.push_back(mk(0,0,  0,0,0,0,0,0,     8,  0,0,1,0,  0,0,0));
    tbl.push_back(mk(0,1,100,0,0,0,0,0,     4,100,0,1,0,  0,0,0));
    tbl.push_back(mk(0,1, 50,0,0,0,0,0,     4,150,0,1,0,  0,0,0));
    tbl.push_back(mk(0,0,  0,1,2,0,0,0,     2,150,1,2,0, 50,0,0));
    tbl.push_back(mk(0,0,  0,0,0,0,1,0,     1,150,0,2,1, 50,0,0));
    tbl.push_back(mk(0,0,  0,0,0,0,0,0,     1,150,0,2,1, 50,0,0));
    tbl.push_back(mk(0,0,  0,0,0,0,0,1,     8,  0,0,2,0,  0,0,0));
    tbl.push_back(mk(0,1,100,0,0,0,0,0,     4,100,0,2,0,  0,0,0));
    tbl.push_back(mk(0,1, 90,0,0,0,0,0,     4,190,0,2,0,  0,0,0));
    tbl.push_back(mk(0,1, 25,0,0,0,0,0,     4,190,0,2,0,  0,1,0)); // over ceiling
    tbl.push_back(mk(0,1, 10,0,0,0,0,0,     4,200,0,2,0,  0,0,0)); // exactly ceiling
    tbl.push_back(mk(0,1,  1,0,0,0,0,0,     4,200,0,2,0,  0,1,0));
    tbl.push_back(mk(0,0,  0,0,0,1,0,0,     1,200,0,2,1,200,0,0));
    tbl.push_back(mk(0,0,  0,0,0,0,0,1,     8,  0,0,2,0,  0,0,0));
    tbl.push_back(mk(0,1, 40,0,0,0,0,0,     4, 40,0,2,0,  0,0,0));
    tbl.push_back(mk(0,0,  0,1,0,0,0,0,     4, 40,0,2,0,  0,0,1)); // short credit
    tbl.push_back(mk(0,1, 10,0,0,1,0,0,     1, 40,0,2,1, 40,1,0)); // cancel beats coin
    tbl.push_back(mk(0,1,  5,1,1,0,0,0,     1, 40,0,2,1, 40,1,1)); // strobes in refund
    tbl.push_back(mk(0,0,  0,0,0,0,0,1,     8,  0,0,2,0,  0,0,0));
    tbl.push_back(mk(0,1,  0,0,0,0,0,0,     8,  0,0,2,0,  0,1,0)); // zero coin
    tbl.push_back(mk(0,1,201,0,0,0,0,0,     8,  0,0,2,0,  0,1,0));
    tbl.push_back(mk(0,1,200,0,0,0,0,0,     4,200,0,2,0,  0,0,0));
    tbl.push_back(mk(0,0,  0,1,0,1,0,0,     1,200,0,2,1,200,0,1)); // cancel beats sel
    tbl.push_back(mk(0,0,  0,0,0,0,0,1,     8,  0,0,2,0,  0,0,0));
    tbl.push_back(mk(0,1,120,0,0,0,0,0,     4,120,0,2,0,  0,0,0));
    tbl.push_back(mk(0,0,  0,1,3,0,0,0,     2,120,1,3,0,  0,0,0));
    tbl.push_back(mk(1,0,  0,0,0,0,1,0,     8,  0,0,0,0,  0,0,0)); // reset beats ack

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].cv, tbl[i].cval, tbl[i].sv, tbl[i].si, tbl[i].ca, tbl[i].da, tbl[i].ka);
      check($sformatf("vec%0d", i), get_out(), tbl[i].exp);
    end

`ifdef VEND_TIMEOUT_EN
    begin
      out_t e;
      drive(1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 30, 0, 0, 0, 0, 0);
      e = '0; e.push = 4'b0100; e.credit = 8'd30;
      check("to_coin30", get_out(), e);
      for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 5, 0, 0, 0, 0, 0);
      for (int k = 0; k < 15; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
      e.credit = 8'd35;
      check("to_restart_hold", get_out(), e);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      e.push = 4'b0001; e.kv = 1'b1; e.kval = 8'd35;
      check("to_refund", get_out(), e);
    end
`endif

    model_step(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    check("rand_reset", get_out(), model_out());
    for (int n = 0; n < 4000; n++) begin
      bit r, cv, sv, ca, da, ka;
      int cval, si;
      r  = ($urandom_range(0, 199) == 0);
      cv = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 7))
        0: cval = 0;
        1: cval = 5;
        2: cval = 10;
        3: cval = 25;
        4: cval = 50;
        5: cval = 100;
        default: cval = $urandom_range(0, 255);
      endcase
      sv = ($urandom_range(0, 5) == 0);
      si = $urandom_range(0, NI - 1);
      ca = ($urandom_range(0, 19) == 0);
      da = ($urandom_range(0, 2) == 0);
      ka = ($urandom_range(0, 2) == 0);
      model_step(r, cv, cval, sv, si, ca, da, ka);
      drive(r, cv, cval, sv, si, ca, da, ka);
      check($sformatf("rand%0d", n), get_out(), model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
